// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order requests to a
// variable-latency instruction memory, buffers returned words in a small
// FIFO towards decode and applies core redirects (branch/jump/jr/IRQ/EXC).
// The kernel bit PC[KBIT] is carried through sequential fetch unchanged and
// is masked off the memory address.
module fetch_queue_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     KBIT     = 31,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] IRQ_VEC  = 32'h8000_0004,
   parameter logic [XLEN-1:0] EXC_VEC  = 32'h8000_0008
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            redir_valid_i,
   input  logic [2:0]      redir_type_i,
   input  logic [XLEN-1:0] redir_target_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   output logic            inst_kernel_o
);

   localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     CW       = $clog2(DEPTH + 1);
   localparam int unsigned     SW       = CW + 1;
   localparam logic [SW-1:0]   DEPTH_W  = SW'(DEPTH);
   localparam logic [CW-1:0]   ONE_C    = CW'(1);
   localparam logic [CW-1:0]   ZERO_C   = {CW{1'b0}};
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
   localparam logic [XLEN-1:0] KMASK    = {{(XLEN-1){1'b0}}, 1'b1} << KBIT;
   localparam logic [XLEN-1:0] LOW_MASK = KMASK - {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

   // Circular pointer advance that also works for non power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == LAST_PTR) r = {PW{1'b0}};
      else               r = p + PW'(1);
      return r;
   endfunction

   // Sequential PC step: the low KBIT bits wrap, the kernel bit and above hold.
   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return (pc & ~LOW_MASK) | ((pc + PC_STEP) & LOW_MASK);
   endfunction

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   disc_q, disc_d;
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [31:0]     fifo_inst_q [DEPTH];
   logic [XLEN-1:0] fifo_pc_q   [DEPTH];
   logic [XLEN-1:0] tag_q       [DEPTH];

   logic            req_s, acc_s, rsp_s, drop_s, push_s, pop_s, redir_s;
   logic [XLEN-1:0] tgt_s;
   logic [SW-1:0]   inflight_s;

   // Request/response qualification and redirect decode.
   always_comb begin
      inflight_s = {1'b0, cnt_q} + {1'b0, outst_q};
      // Reset gates the request so it is low immediately while reset is held.
      req_s  = ~reset & (inflight_s < DEPTH_W);
      acc_s  = req_s & imem_ready_i;
      // A response with nothing outstanding is a protocol error and ignored.
      rsp_s  = imem_rvalid_i & (outst_q != ZERO_C);
      redir_s = 1'b0;
      tgt_s   = pc_q;
      case (redir_type_i)
         3'b001, 3'b010, 3'b011: begin
            redir_s = redir_valid_i;
            tgt_s   = redir_target_i;
         end
         3'b100: begin
            redir_s = redir_valid_i;
            tgt_s   = IRQ_VEC;
         end
         3'b101: begin
            redir_s = redir_valid_i;
            tgt_s   = EXC_VEC;
         end
         default: begin
            redir_s = 1'b0;
            tgt_s   = pc_q;
         end
      endcase
      drop_s = rsp_s & (disc_q != ZERO_C);
      // A response in the redirect cycle is stale and is never enqueued.
      push_s = rsp_s & ~drop_s & ~redir_s;
      pop_s  = inst_ready_i & (cnt_q != ZERO_C) & ~redir_s;
   end

   // Next-state for PC, counters and queue pointers.
   always_comb begin
      outst_d = outst_q;
      if (acc_s) outst_d = outst_d + ONE_C;
      else       outst_d = outst_d;
      if (rsp_s) outst_d = outst_d - ONE_C;
      else       outst_d = outst_d;

      tag_wr_d = acc_s ? ptr_inc(tag_wr_q) : tag_wr_q;
      tag_rd_d = rsp_s ? ptr_inc(tag_rd_q) : tag_rd_q;

      if (redir_s) begin
         // Everything still in flight after this edge belongs to the old path.
         pc_d   = tgt_s;
         disc_d = outst_d;
         cnt_d  = ZERO_C;
         wr_d   = {PW{1'b0}};
         rd_d   = {PW{1'b0}};
      end else begin
         pc_d   = acc_s ? pc_next(pc_q) : pc_q;
         disc_d = drop_s ? (disc_q - ONE_C) : disc_q;
         cnt_d  = cnt_q;
         if (push_s) cnt_d = cnt_d + ONE_C;
         else        cnt_d = cnt_d;
         if (pop_s)  cnt_d = cnt_d - ONE_C;
         else        cnt_d = cnt_d;
         wr_d   = push_s ? ptr_inc(wr_q) : wr_q;
         rd_d   = pop_s  ? ptr_inc(rd_q) : rd_q;
      end
   end

   // State registers, cleared asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         cnt_q    <= ZERO_C;
         outst_q  <= ZERO_C;
         disc_q   <= ZERO_C;
         wr_q     <= {PW{1'b0}};
         rd_q     <= {PW{1'b0}};
         tag_wr_q <= {PW{1'b0}};
         tag_rd_q <= {PW{1'b0}};
      end else begin
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         outst_q  <= outst_d;
         disc_q   <= disc_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         tag_wr_q <= tag_wr_d;
         tag_rd_q <= tag_rd_d;
      end
   end

   // Tag queue and instruction FIFO storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_inst_q[i] <= 32'h0000_0000;
            fifo_pc_q[i]   <= {XLEN{1'b0}};
            tag_q[i]       <= {XLEN{1'b0}};
         end
      end else begin
         if (acc_s) tag_q[tag_wr_q] <= pc_q;
         if (push_s) begin
            fifo_inst_q[wr_q] <= imem_rdata_i;
            fifo_pc_q[wr_q]   <= tag_q[tag_rd_q];
         end
      end
   end

   // Outputs derived only from registered state (plus the reset gate on req).
   always_comb begin
      imem_req_o    = req_s;
      imem_addr_o   = pc_q & ~KMASK;
      inst_valid_o  = (cnt_q != ZERO_C);
      if (inst_valid_o) begin
         inst_o    = fifo_inst_q[rd_q];
         inst_pc_o = fifo_pc_q[rd_q];
      end else begin
         inst_o    = 32'h0000_0000;
         inst_pc_o = {XLEN{1'b0}};
      end
      inst_kernel_o = inst_pc_o[KBIT];
   end

endmodule
